note_player: RTL and testbench

- Sequential consumer of the note frequency table: accepts note commands (index, octave select, length) over a valid/ready handshake.
- Drives the table address and octave-select lines, captures the returned 8-bit half-period entry, and produces a square-wave tone for a fixed number of beats.
- Sits between the song sequencer (upstream) and the audio output pin (downstream); the frequency table is an external combinational block.

---
 rtl/note_player.sv | 156 +++++++++++++++
 tb/tb_note_player.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Note player: takes note commands, looks up the half-period in an external table,
// and plays a square-wave tone for (len+1) beats. Define NOTE_GAP_EN for a silent gap after each note.
module note_player #(
  parameter int unsigned PRESCALE   = 2,
  parameter int unsigned BEAT_TICKS = 256,
  parameter int unsigned GAP_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_idx,
  input  logic       note_high,
  input  logic [3:0] note_len,
  output logic [3:0] db_address,
  output logic       db_highkey,
  input  logic [7:0] db_entry,
  output logic       tone_out,
  output logic       busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = $clog2(BEAT_TICKS);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CYC_MAX = CW'(BEAT_TICKS - 1);

`ifdef NOTE_GAP_EN
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TICKS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  logic [GW-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic          high_q, high_d;
  logic [3:0]    len_q, len_d;
  logic [7:0]    period_q, period_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    half_q, half_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    beat_q, beat_d;
  logic          tone_q, tone_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      high_q   <= 1'b0;
      len_q    <= '0;
      period_q <= '0;
      pre_q    <= '0;
      half_q   <= '0;
      cyc_q    <= '0;
      beat_q   <= '0;
      tone_q   <= 1'b0;
`ifdef NOTE_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      high_q   <= high_d;
      len_q    <= len_d;
      period_q <= period_d;
      pre_q    <= pre_d;
      half_q   <= half_d;
      cyc_q    <= cyc_d;
      beat_q   <= beat_d;
      tone_q   <= tone_d;
`ifdef NOTE_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    high_d   = high_q;
    len_d    = len_q;
    period_d = period_q;
    pre_d    = pre_q;
    half_d   = half_q;
    cyc_d    = cyc_q;
    beat_d   = beat_q;
    tone_d   = tone_q;
`ifdef NOTE_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (note_valid) begin
          addr_d  = note_idx;
          high_d  = note_high;
          len_d   = note_len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        period_d = db_entry;
        pre_d    = '0;
        half_d   = '0;
        cyc_d    = '0;
        beat_d   = '0;
        tone_d   = 1'b0;
        state_d  = PLAY;
      end
      PLAY: begin
        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        // A zero period is a rest: the half-period counter stays parked.
        if (pre_q == PRE_MAX && period_q != '0) begin
          if (half_q == period_q - 8'd1) begin
            tone_d = ~tone_q;
            half_d = '0;
          end else begin
            half_d = half_q + 8'd1;
          end
        end
        if (cyc_q == CYC_MAX) begin
          cyc_d = '0;
          if (beat_q == len_q) begin
            tone_d = 1'b0;
`ifdef NOTE_GAP_EN
            gap_d   = '0;
            state_d = GAP;
`else
            state_d = IDLE;
`endif
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`ifdef NOTE_GAP_EN
      GAP: begin
        tone_d = 1'b0;
        if (gap_q == GAP_MAX) state_d = IDLE;
        else                  gap_d   = gap_q + 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign note_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign db_address = addr_q;
  assign db_highkey = high_q;
  assign tone_out   = tone_q;

endmodule

// File: tb/tb_note_player.sv
// Randomized bench for note_player: a timeline model predicts busy/ready/tone
// from the time since the last accepted command.
module tb_note_player;

  localparam int PS = 2;
  localparam int BT = 256;
`ifdef NOTE_GAP_EN
  localparam int GT = 8;
`else
  localparam int GT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_high = 1'b0;
  logic [3:0] note_idx = '0;
  logic [3:0] note_len = '0;
  logic       note_ready, db_highkey, tone_out, busy;
  logic [3:0] db_address;
  logic [7:0] db_entry;

  int n_checks = 0;
  int n_errors = 0;

  note_player #(.PRESCALE(PS), .BEAT_TICKS(BT), .GAP_TICKS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_idx   (note_idx),
    .note_high  (note_high),
    .note_len   (note_len),
    .db_address (db_address),
    .db_highkey (db_highkey),
    .db_entry   (db_entry),
    .tone_out   (tone_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tbl(input logic [3:0] a, input logic h);
    if (a == 4'd13) return 8'd0;
    if (!h) return (a == 4'd0) ? 8'd51 : 8'(20 + 3 * int'(a));
    return (a == 4'd9) ? 8'd30 : 8'(10 + 2 * int'(a));
  endfunction

  assign db_entry = tbl(db_address, db_highkey);

  // Model: k = cycles since the accept edge; k=1 is LOAD, then PLAY, then GAP.
  bit         m_active = 1'b0;
  int         m_k = 0, m_p = 0, m_l = 0, n_acc = 0;
  logic [3:0] m_addr = '0;
  logic       m_high = 1'b0;

  function automatic int m_play_end();
    return 1 + (m_l + 1) * BT;
  endfunction

  function automatic bit m_busy();
    return m_active && m_k >= 1 && m_k <= m_play_end() + GT;
  endfunction

  function automatic bit m_tone();
    if (!m_busy() || m_k < 2 || m_k > m_play_end() || m_p == 0) return 1'b0;
    return (((m_k - 2) / (m_p * PS)) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("busy",  32'(busy),       32'(m_busy()));
    check("ready", 32'(note_ready), 32'(!m_busy()));
    check("tone",  32'(tone_out),   32'(m_tone()));
    check("addr",  32'(db_address), 32'(m_addr));
    check("high",  32'(db_highkey), 32'(m_high));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0; m_addr = '0; m_high = 1'b0;
    end else if (!m_busy() && note_valid) begin
      m_active = 1'b1; m_k = 1;
      m_addr = note_idx; m_high = note_high; m_l = int'(note_len);
      m_p = int'(tbl(note_idx, note_high));
      n_acc++;
    end else if (m_active) begin
      m_k++;
      if (m_k > m_play_end() + GT) m_active = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [3:0] idx, input logic h, input logic [3:0] len);
    int start, c;
    start = n_acc;
    c = 0;
    note_idx = idx; note_high = h; note_len = len; note_valid = 1'b1;
    while (n_acc == start && c < 5000) begin tick(); c++; end
    if (n_acc == start) check("accept_timeout", 0, 1);
    note_valid = 1'b0;
  endtask

  // Runs the current note out; returns busy cycles after accept and first tone rise.
  task automatic play_out(input bit scramble, output int c, output int rise);
    c = 0;
    rise = -1;
    while (busy && c < 6000) begin
      tick();
      c++;
      if (tone_out && rise < 0) rise = c;
      if (scramble) begin
        note_idx = 4'($urandom); note_high = 1'($urandom); note_len = 4'($urandom);
      end
    end
    if (c >= 6000) check("busy_timeout", 0, 1);
  endtask

  initial begin
    int c, rise;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic tone: period 51 -> rise at PLAY offset 102 (count includes LOAD).
    send(4'd0, 1'b0, 4'd0);
    play_out(1'b0, c, rise);
    check("basic_len",  c,    1 + BT + GT);
    check("basic_rise", rise, 1 + 51 * PS);
    repeat (2) tick();

    // High octave, three beats.
    send(4'd9, 1'b1, 4'd2);
    check("hi_addr", 32'(db_address), 9);
    check("hi_key",  32'(db_highkey), 1);
    play_out(1'b1, c, rise);
    check("hi_len",  c,    1 + 3 * BT + GT);
    check("hi_rise", rise, 1 + 30 * PS);
    tick();

    // Rest note: no tone at all.
    send(4'd13, 1'b0, 4'd1);
    play_out(1'b0, c, rise);
    check("rest_len",  c,    1 + 2 * BT + GT);
    check("rest_rise", rise, -1);
    tick();

    // Back-to-back: valid held; second accept only after one IDLE cycle.
    send(4'd0, 1'b0, 4'd0);
    note_valid = 1'b1; note_idx = 4'd9; note_high = 1'b1; note_len = 4'd0;
    c = 0;
    while (n_acc < 5 && c < 5000) begin tick(); c++; end
    check("b2b_gap", c, 2 + BT + GT);
    note_valid = 1'b0;
    play_out(1'b0, c, rise);
    tick();

    // Randomized notes with input scrambling during play.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(4'($urandom), 1'($urandom), 4'($urandom_range(0, 2)));
      play_out(1'b1, c, rise);
      check("rnd_len", c, m_play_end() + GT);
    end
    note_idx = '0; note_high = 1'b0; note_len = '0;

    // Reset in the middle of PLAY.
    send(4'd3, 1'b0, 4'd2);
    repeat (300) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tone", 32'(tone_out),   0);
    check("rst_busy", 32'(busy),       0);
    check("rst_addr", 32'(db_address), 0);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (400) tick();
    check("post_rst_ready", 32'(note_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
